// File: rtl/reg_file_wr_arb_pkg.sv
// Shared types and helpers for the round-robin register-bank write arbiter.
// Holds the arbiter state encoding, the grant-id width and parameter legality.
package reg_file_wr_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // A single requester would still need a 1-bit id field.
  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_ok(input int req_num, input int reg_num,
                                   input int addr_width, input int lock_max);
    return (req_num >= 2) && (req_num <= 8) &&
           (reg_num >= 2) && ((reg_num & (reg_num - 1)) == 0) &&
           (addr_width == $clog2(reg_num)) && (lock_max >= 2);
  endfunction

endpackage

// File: rtl/reg_file_wr_arb_pick.sv
// Combinational round-robin picker: first valid request at or after the
// pointer, or only the owner while a lock is held.
module rr_arb_pick
  import reg_file_wr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = gid_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_lock_en,
  input  logic [IW-1:0] i_owner,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  int w_j;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_j       = 0;
    if (i_lock_en) begin
      if (i_req[i_owner]) begin
        o_gnt[i_owner] = 1'b1;
        o_gnt_idx      = i_owner;
      end
    end else begin
      // Scan farthest-first so the nearest valid request overwrites the rest.
      for (int i = N - 1; i >= 0; i--) begin
        w_j = (int'(i_ptr) + i) % N;
        if (i_req[w_j]) begin
          o_gnt      = '0;
          o_gnt[w_j] = 1'b1;
          o_gnt_idx  = IW'(w_j);
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arb.sv
// Round-robin write arbiter with burst locking in front of a small register
// bank; one write per cycle and a combinational read port.
module reg_file_wr_arb
  import reg_file_wr_arb_pkg::*;
#(
  parameter int                    REQ_NUM    = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_NUM    = 8,
  parameter int                    ADDR_WIDTH = $clog2(REG_NUM),
  parameter int                    LOCK_MAX   = 4,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
  localparam int                   IW         = gid_w(REQ_NUM)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [REQ_NUM-1:0]                   i_req_valid,
  input  logic [REQ_NUM-1:0]                   i_req_lock,
  input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]   i_req_data,
  output logic [REQ_NUM-1:0]                   o_req_ready,
  input  logic [ADDR_WIDTH-1:0]                i_rd_addr,
  output logic [DATA_WIDTH-1:0]                o_rd_data,
  output logic                                 o_grant_valid,
  output logic [IW-1:0]                        o_grant_id
);

  localparam int CW = $clog2(LOCK_MAX);

  if (!params_ok(REQ_NUM, REG_NUM, ADDR_WIDTH, LOCK_MAX)) begin : g_param_err
    $error("reg_file_wr_arb: illegal parameter set");
  end

  arb_state_e            r_state, w_state_nxt;
  logic [IW-1:0]         r_ptr, w_ptr_nxt;
  logic [IW-1:0]         r_owner, w_owner_nxt;
  logic [CW-1:0]         r_lock_cnt, w_lock_cnt_nxt;
  logic [REQ_NUM-1:0]    w_gnt;
  logic [IW-1:0]         w_gnt_idx;
  logic                  w_xfer;
  logic                  w_lock_bit;
  logic [DATA_WIDTH-1:0] r_bank [REG_NUM];
  logic                  r_grant_valid;
  logic [IW-1:0]         r_grant_id;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] x);
    return (x == IW'(REQ_NUM - 1)) ? '0 : x + 1'b1;
  endfunction

  rr_arb_pick #(
    .N  (REQ_NUM),
    .IW (IW)
  ) u_pick (
    .i_req     (i_req_valid),
    .i_ptr     (r_ptr),
    .i_lock_en (r_state == LOCK),
    .i_owner   (r_owner),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign o_req_ready = w_gnt;
  assign w_xfer      = |w_gnt;
  assign w_lock_bit  = i_req_lock[w_gnt_idx];

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ARB: begin
        if (w_xfer) begin
          w_ptr_nxt = ptr_inc(w_gnt_idx);
          if (w_lock_bit) begin
            w_state_nxt    = LOCK;
            w_owner_nxt    = w_gnt_idx;
            w_lock_cnt_nxt = CW'(1);
          end
        end
      end
      LOCK: begin
        // No transfer here means the owner dropped valid, which also releases.
        if (w_xfer && w_lock_bit && (r_lock_cnt < CW'(LOCK_MAX - 1))) begin
          w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end else begin
          w_state_nxt    = ARB;
          w_ptr_nxt      = ptr_inc(r_owner);
          w_lock_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ARB;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_bank[i] <= RST_VAL;
      end
    end else if (w_xfer) begin
      r_bank[i_req_addr[w_gnt_idx]] <= i_req_data[w_gnt_idx];
    end
  end

  assign o_rd_data = r_bank[i_rd_addr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
    end else begin
      r_grant_valid <= w_xfer;
      if (w_xfer) begin
        r_grant_id <= w_gnt_idx;
      end
    end
  end

  assign o_grant_valid = r_grant_valid;
  assign o_grant_id    = r_grant_id;

endmodule

// File: tb/tb_reg_file_wr_arb.sv
// Self-checking bench for reg_file_wr_arb: directed scenarios plus random
// traffic compared against a behavioural model of the arbitration rules.
module tb_reg_file_wr_arb;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int RN = 8;
  localparam int LM = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          valid;
  logic [N-1:0]          lock;
  logic [N-1:0][AW-1:0]  addr;
  logic [N-1:0][DW-1:0]  data;
  logic [AW-1:0]         rd_addr;
  logic [N-1:0]          ready;
  logic [DW-1:0]         rd_data;
  logic                  gv;
  logic [1:0]            gid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_ptr;
  bit          m_locked;
  int          m_owner;
  int          m_burst;
  logic [DW-1:0] m_bank [RN];
  bit          m_gv;
  int          m_gid;
  int          last_gnt;
  logic [N-1:0] last_ready;

  always #5 clk = ~clk;

  reg_file_wr_arb #(
    .REQ_NUM    (N),
    .DATA_WIDTH (DW),
    .REG_NUM    (RN),
    .ADDR_WIDTH (AW),
    .LOCK_MAX   (LM),
    .RST_VAL    ('0)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (valid),
    .i_req_lock    (lock),
    .i_req_addr    (addr),
    .i_req_data    (data),
    .o_req_ready   (ready),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_grant_valid (gv),
    .o_grant_id    (gid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_locked = 0;
    m_owner  = 0;
    m_burst  = 0;
    m_gv     = 0;
    m_gid    = 0;
    for (int i = 0; i < RN; i++) m_bank[i] = '0;
  endtask

  // Who should win this cycle: the owner only during a burst, else the
  // first valid requester walking upward from the pointer.
  function automatic int exp_grant();
    if (m_locked) return valid[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      if (valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_release();
    m_locked = 0;
    m_ptr    = (m_owner + 1) % N;
  endtask

  task automatic model_update(input int g);
    m_gv = (g >= 0);
    if (g >= 0) begin
      m_gid = g;
      m_bank[addr[g]] = data[g];
    end
    if (m_locked) begin
      if (g < 0) model_release();
      else begin
        m_burst++;
        if (!lock[g] || m_burst == LM) model_release();
      end
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (lock[g]) begin
        m_locked = 1;
        m_owner  = g;
        m_burst  = 1;
      end
    end
  endtask

  // Called 1ns after a rising edge with inputs already driven for this cycle.
  task automatic step();
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g  = exp_grant();
    er = (g >= 0) ? N'(1 << g) : '0;
    check("ready", 32'(ready), 32'(er));
    check("rd_data", rd_data, m_bank[rd_addr]);
    check("gnt_vld", 32'(gv), 32'(m_gv));
    if (m_gv) check("gnt_id", 32'(gid), m_gid);
    last_gnt   = g;
    last_ready = ready;
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic do_reset();
    valid = '0;
    lock  = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int ord [5];
    ord     = '{0, 1, 2, 3, 0};
    rst_n   = 1'b0;
    valid   = '0;
    lock    = '0;
    addr    = '0;
    data    = '0;
    rd_addr = '0;
    model_reset();
    #1;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_gv", 32'(gv), 32'h0);
    check("rst_gid", 32'(gid), 32'h0);
    for (int a = 0; a < RN; a++) begin
      rd_addr = AW'(a);
      #1;
      check("rst_bank", rd_data, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All four requesters contending, no locks
    valid   = 4'hF;
    rd_addr = 3'd2;
    for (int k = 0; k < N; k++) begin
      addr[k] = AW'(k);
      data[k] = 32'h10 + k;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_order", last_gnt, ord[i]);
      if (i == 2) check("rd_r2", rd_data, 32'h12);
    end

    // Lone requester 2, then 0 vs 3 after pointer moved to 3
    do_reset();
    valid = 4'b0100;
    step();
    check("solo2", last_gnt, 2);
    valid = 4'b1001;
    step();
    check("p3_wins", last_gnt, 3);

    // Forced release after LOCK_MAX grants
    do_reset();
    valid = 4'b0001;
    step();
    valid   = 4'b0011;
    lock    = 4'b0010;
    addr[1] = 3'd3;
    data[1] = 32'hCAFE_0001;
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_seq", last_gnt, (i < 4) ? 1 : 0);
      if (i < 4) check("rdy0_low", 32'(last_ready[0]), 32'h0);
    end

    // Owner drops valid for one cycle to release the lock
    do_reset();
    valid = 4'b0001;
    step();
    valid = 4'b1010;
    lock  = 4'b0010;
    step();
    check("lk_grant", last_gnt, 1);
    valid = 4'b1000;
    step();
    check("drop_nogrant", last_gnt, -1);
    step();
    check("after_drop", last_gnt, 3);

    // Asynchronous reset in the middle of a burst (two beats in)
    do_reset();
    valid = 4'b0001;
    step();
    valid   = 4'b0011;
    lock    = 4'b0010;
    addr[1] = 3'd1;
    data[1] = 32'hA5A5_0001;
    rd_addr = 3'd1;
    step();
    step();
    check("mr_pre_rd", rd_data, 32'hA5A5_0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_ready", 32'(ready), 32'h1);
    check("mr_gv", 32'(gv), 32'h0);
    for (int a = 0; a < RN; a++) begin
      rd_addr = AW'(a);
      #1;
      check("mr_bank", rd_data, 32'h0);
    end
    model_reset();
    valid = '0;
    lock  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    valid = 4'b0011;
    step();
    check("mr_ord0", last_gnt, 0);
    step();
    check("mr_ord1", last_gnt, 1);

    // Read of a register in the same cycle it is written
    do_reset();
    valid   = 4'b0001;
    addr[0] = 3'd5;
    data[0] = 32'h55;
    rd_addr = 3'd5;
    step();
    data[0] = 32'hDEAD_BEEF;
    check("rd_old", rd_data, 32'h55);
    step();
    check("rd_new", rd_data, 32'hDEAD_BEEF);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      valid = N'($urandom);
      lock  = N'($urandom) & N'($urandom);
      for (int k = 0; k < N; k++) begin
        addr[k] = AW'($urandom_range(RN - 1));
        data[k] = $urandom;
      end
      rd_addr = AW'($urandom_range(RN - 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_wr_arb.md
# reg_file_wr_arb

Round-robin write arbiter and storage for a small shared register bank. Up to REQ_NUM requesters compete for a single write port using a valid/ready handshake; the winner's data is committed into one of REG_NUM registers on the same clock edge. A requester may lock the port for a bounded burst. One combinational read port serves consumers such as CSR readback and debug.

## Interface
- REQ_NUM, 4: number of write requesters (2..8).
- DATA_WIDTH, 32: register data width.
- REG_NUM, 8: registers in the bank (power of two, >= 2).
- ADDR_WIDTH, $clog2(REG_NUM): register address width.
- LOCK_MAX, 4: maximum consecutive grants to one locking requester (>= 2).
- RST_VAL, '0: reset value of every register.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  REQ_NUM  per-requester write request.
- i_req_lock  in  REQ_NUM  per-requester: keep the grant after this beat.
- i_req_addr  in  REQ_NUM x ADDR_WIDTH  target register per requester.
- i_req_data  in  REQ_NUM x DATA_WIDTH  write data per requester.
- o_req_ready  out  REQ_NUM  one-hot grant, combinational.
- i_rd_addr  in  ADDR_WIDTH  read address.
- o_rd_data  out  DATA_WIDTH  combinational read of the bank.
- o_grant_valid  out  1  registered: a write was committed on the previous edge.
- o_grant_id  out  $clog2(REQ_NUM)  registered: index of that writer.

## Operation
- Handshake: a beat transfers on an edge where i_req_valid[k] && o_req_ready[k]. At most one ready bit is high per cycle. Ready is never high without valid.
- Priority pointer ptr resets to 0, giving order 0,1,..,REQ_NUM-1. The grant goes to the first valid requester searching from ptr upward, with wraparound. After a transfer by k, ptr <= (k+1) mod REQ_NUM.
- FSM states: ARB and LOCK. Reset state is ARB.
  - ARB to LOCK: a transfer by k with i_req_lock[k]=1. Record owner <= k and set lock_cnt <= 1.
  - In LOCK, only the owner can be granted. The other requesters see ready=0 even if the owner is idle.
  - LOCK, owner transfers with lock=1 and lock_cnt < LOCK_MAX-1: stay in LOCK and increment lock_cnt.
  - LOCK to ARB, on any of these:
    - the owner transfers with lock=0;
    - the owner transfers with lock_cnt = LOCK_MAX-1 (forced release);
    - the owner deasserts valid for one cycle, which releases the lock with no transfer.
  - On any exit from LOCK, ptr <= owner+1.
- Write: on a transfer, bank[i_req_addr[k]] <= i_req_data[k]. No other register changes.
- Read: o_rd_data = bank[i_rd_addr]. It shows pre-edge contents, with no write bypass.
- Reset values: all bank entries = RST_VAL, o_grant_valid=0, o_grant_id=0, ptr=0, lock_cnt=0, state=ARB. o_req_ready is 0 whenever all i_req_valid are 0.
- Reset asserted mid-burst: state returns to ARB immediately and asynchronously, and bank contents return to RST_VAL. An in-flight beat on that edge is dropped.
- Bits of i_req_lock for non-granted requesters are ignored.

## Timing
- Write latency: data is readable on o_rd_data in the cycle after the transfer edge.
- o_grant_valid/o_grant_id: asserted for exactly one cycle after each transfer edge.
- Throughput: one write per cycle, sustained under contention.
- Fairness: in ARB, a continuously valid requester waits at most REQ_NUM-1 transfers. In the worst case with locks, the wait is bounded by (REQ_NUM-1) x LOCK_MAX transfers plus one idle release cycle per lock.
- The path from i_req_valid to o_req_ready is combinational, so requesters must not make valid depend on ready.

## Structure
- Package reg_file_wr_arb_pkg holds:
  - the state enum typedef (ARB, LOCK);
  - the grant-id width function;
  - parameter sanity checks as elaboration-time assertions.
- Sub-module rr_arb_pick (combinational):
  - inputs: request vector, pointer, lock-enable, and owner index;
  - outputs: one-hot grant and encoded index.
- The top level holds the FSM, ptr, lock_cnt, the bank array with asynchronous reset, and the grant output registers.

## Test plan
- Reset, then all four requesters continuously valid with lock=0, addr=k, data=0x10+k. Required grant order 0,1,2,3,0. Reading register 2 returns 0x12 one cycle after the third grant.
- Only requester 2 valid from reset: it is granted immediately. ptr becomes 3; next, requesters 0 and 3 both valid, and 3 wins.
- Requester 1 holds lock=1 with valid continuous, REQ_NUM=4, LOCK_MAX=4, while requester 0 is valid throughout. Required sequence: four grants to 1, then 0 is granted (forced release). Meanwhile o_req_ready[0]=0 throughout the burst.
- Requester 1 locks and then drops valid for one cycle while requester 3 is valid. Required: no grant in the drop cycle, state returns to ARB, then 3 is granted.
- Assert i_rst_n=0 mid-burst (lock_cnt=2). Required: immediate ARB, all registers = RST_VAL, o_grant_valid=0; after release, ptr=0 ordering resumes.
- Write 0xDEADBEEF to register 5 while reading register 5 in the same cycle. Required: old value in that cycle, 0xDEADBEEF in the next.
